// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: FunSel opcodes and the read-select
// width helper used by the top-level port list.
package reg_bank_pkg;

    // FunSel operation codes, shared by every register cell.
    typedef enum logic [2:0] {
        OP_DEC  = 3'b000,
        OP_INC  = 3'b001,
        OP_LOAD = 3'b010,
        OP_CLR  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_LDLO = 3'b110,
        OP_HOLD = 3'b111
    } funsel_e;

    // Width of a register index: a single-register bank still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : reg_bank_pkg

// File: rtl/reg_cell.sv
// One register of the bank. Applies the shared FunSel operation when enabled
// and raises a one-cycle Wrap pulse after an overflow, underflow or a shift
// that drops a 1 out of the MSB.
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int              WIDTH    = 16,
    parameter int              SATURATE = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);

    // For odd widths the low half is floor(WIDTH/2) bits.
    localparam int              LO_W     = WIDTH / 2;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] LO_MASK  = {{(WIDTH - LO_W){1'b0}}, {LO_W{1'b1}}};

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Next value and wrap condition for the selected operation.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (no latch).
        w_next = r_q;
        w_wrap = 1'b0;
        if (E) begin
            case (funsel_e'(FunSel))
                OP_DEC: begin
                    if (r_q == '0) begin
                        w_wrap = 1'b1;
                        w_next = (SATURATE != 0) ? '0 : ALL_ONES;
                    end else begin
                        w_next = r_q - ONE;
                    end
                end
                OP_INC: begin
                    if (r_q == ALL_ONES) begin
                        w_wrap = 1'b1;
                        w_next = (SATURATE != 0) ? ALL_ONES : '0;
                    end else begin
                        w_next = r_q + ONE;
                    end
                end
                OP_LOAD: w_next = I;
                OP_CLR:  w_next = '0;
                OP_SHL: begin
                    w_next = {r_q[WIDTH-2:0], 1'b0};
                    w_wrap = r_q[WIDTH-1];
                end
                OP_SHR:  w_next = {1'b0, r_q[WIDTH-1:1]};
                OP_LDLO: w_next = (r_q & ~LO_MASK) | (I & LO_MASK);
                default: w_next = r_q;
            endcase
        end
    end

    // State register: synchronous reset wins over any operation in the same cycle.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all cells sample pre-edge values together.
        if (Reset) begin
            r_q    <= RST_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_next;
            r_wrap <= w_wrap;
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule : reg_cell

// File: rtl/reg_file_bank.sv
// Bank of NREG independent registers sharing one opcode and load bus, with two
// combinational read ports and a per-register zero flag.
module reg_file_bank
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               NREG     = 4,
    parameter int               SATURATE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    localparam int              SEL_W    = sel_width(NREG)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [NREG-1:0]  E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    input  logic [SEL_W-1:0] RSelA,
    input  logic [SEL_W-1:0] RSelB,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREG-1:0]  Zero,
    output logic [NREG-1:0]  Wrap
);

    logic [WIDTH-1:0] w_q [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        reg_cell #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE),
            .RST_VAL  (RST_VAL)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (E[k]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (w_q[k]),
            .Wrap   (Wrap[k])
        );

        assign Zero[k] = (w_q[k] == '0);
    end

    // Read muxes: an index past the last register reads as zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(RSelA) == k) OutA = w_q[k];
            if (int'(RSelB) == k) OutB = w_q[k];
        end
    end

endmodule : reg_file_bank

// File: tb/tb_reg_file_bank.sv
// Randomized + directed bench for reg_file_bank. Three instances: wrapping and
// saturating 16x4 banks sharing stimulus, and a 7-bit, 3-register bank with a
// non-zero reset value. A behavioural model pushes expected outputs into a
// scoreboard; a monitor on the falling edge pops and compares.
module tb_reg_file_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  e_ab;
    logic [2:0]  fs_ab;
    logic [15:0] i_ab;
    logic [1:0]  ra_ab, rb_ab;
    logic [15:0] outa_a, outb_a, outa_b, outb_b;
    logic [3:0]  zero_a, wrap_a, zero_b, wrap_b;

    logic [2:0]  e_c, fs_c;
    logic [6:0]  i_c;
    logic [1:0]  ra_c, rb_c;
    logic [6:0]  outa_c, outb_c;
    logic [2:0]  zero_c, wrap_c;

    reg_file_bank #(.WIDTH(16), .NREG(4), .SATURATE(0), .RST_VAL(16'h0000)) dut_a (
        .Clock(clk), .Reset(reset), .E(e_ab), .FunSel(fs_ab), .I(i_ab),
        .RSelA(ra_ab), .RSelB(rb_ab), .OutA(outa_a), .OutB(outb_a),
        .Zero(zero_a), .Wrap(wrap_a)
    );

    reg_file_bank #(.WIDTH(16), .NREG(4), .SATURATE(1), .RST_VAL(16'h0000)) dut_b (
        .Clock(clk), .Reset(reset), .E(e_ab), .FunSel(fs_ab), .I(i_ab),
        .RSelA(ra_ab), .RSelB(rb_ab), .OutA(outa_b), .OutB(outb_b),
        .Zero(zero_b), .Wrap(wrap_b)
    );

    reg_file_bank #(.WIDTH(7), .NREG(3), .SATURATE(0), .RST_VAL(7'd5)) dut_c (
        .Clock(clk), .Reset(reset), .E(e_c), .FunSel(fs_c), .I(i_c),
        .RSelA(ra_c), .RSelB(rb_c), .OutA(outa_c), .OutB(outb_c),
        .Zero(zero_c), .Wrap(wrap_c)
    );

    typedef struct {
        int          dut;
        logic [15:0] outa;
        logic [15:0] outb;
        logic [15:0] zero;
        logic [15:0] wrap;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg  [3][4];
    bit          mwrap [3][4];
    bit          model_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int dut_w(input int d);  return (d == 2) ? 7 : 16; endfunction
    function automatic int dut_n(input int d);  return (d == 2) ? 3 : 4;  endfunction
    function automatic bit dut_s(input int d);  return (d == 1);          endfunction
    function automatic int dut_rv(input int d); return (d == 2) ? 5 : 0;  endfunction

    // Behavioural register operation on plain integers.
    function automatic void model_op(input int op, input logic [15:0] v, input logic [15:0] iv,
                                     input int w, input bit s,
                                     output logic [15:0] nv, output bit wr);
        int maxv = (1 << w) - 1;
        int lo   = (1 << (w / 2)) - 1;
        int vi   = int'(v);
        int ii   = int'(iv);
        int r    = vi;
        wr = 1'b0;
        case (op)
            0: if (vi == 0) begin r = s ? 0 : maxv; wr = 1'b1; end else r = vi - 1;
            1: if (vi == maxv) begin r = s ? maxv : 0; wr = 1'b1; end else r = vi + 1;
            2: r = ii & maxv;
            3: r = 0;
            4: begin r = (vi * 2) & maxv; wr = (vi > maxv / 2); end
            5: r = vi / 2;
            6: r = (vi - (vi & lo)) + (ii & lo);
            default: r = vi;
        endcase
        nv = 16'(r);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Push expectations for the current cycle, advance the model over the coming edge.
    task automatic issue();
        for (int d = 0; d < 3; d++) begin
            logic [3:0]  e;
            int          fs, ra, rb;
            logic [15:0] iv;
            logic [15:0] nv;
            bit          wr;
            exp_t        x;
            if (d < 2) begin
                e = e_ab; fs = int'(fs_ab); iv = i_ab; ra = int'(ra_ab); rb = int'(rb_ab);
            end else begin
                e = {1'b0, e_c}; fs = int'(fs_c); iv = {9'b0, i_c}; ra = int'(ra_c); rb = int'(rb_c);
            end
            if (model_valid) begin
                x.dut  = d;
                x.outa = (ra < dut_n(d)) ? mreg[d][ra] : 16'h0;
                x.outb = (rb < dut_n(d)) ? mreg[d][rb] : 16'h0;
                x.zero = '0;
                x.wrap = '0;
                for (int k = 0; k < dut_n(d); k++) begin
                    x.zero[k] = (mreg[d][k] == 16'h0);
                    x.wrap[k] = mwrap[d][k];
                end
                sb.push_back(x);
            end
            for (int k = 0; k < dut_n(d); k++) begin
                if (reset) begin
                    mreg[d][k]  = 16'(dut_rv(d));
                    mwrap[d][k] = 1'b0;
                end else if (e[k]) begin
                    model_op(fs, mreg[d][k], iv, dut_w(d), dut_s(d), nv, wr);
                    mreg[d][k]  = nv;
                    mwrap[d][k] = wr;
                end else begin
                    mwrap[d][k] = 1'b0;
                end
            end
        end
        if (reset) model_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_c();
        e_c  = 3'($urandom);
        fs_c = 3'($urandom);
        case ($urandom_range(0, 3))
            0:       i_c = 7'h00;
            1:       i_c = 7'h7F;
            default: i_c = 7'($urandom);
        endcase
        ra_c = 2'($urandom);
        rb_c = 2'($urandom);
    endtask

    task automatic drive(input logic [3:0] e, input funsel_e fs, input logic [15:0] iv,
                         input logic [1:0] ra, input logic [1:0] rb);
        e_ab = e; fs_ab = fs; i_ab = iv; ra_ab = ra; rb_ab = rb;
        rand_c();
        issue();
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t        x;
                logic [15:0] aa, ab, z, w;
                x = sb.pop_front();
                case (x.dut)
                    0: begin aa = outa_a; ab = outb_a; z = {12'b0, zero_a}; w = {12'b0, wrap_a}; end
                    1: begin aa = outa_b; ab = outb_b; z = {12'b0, zero_b}; w = {12'b0, wrap_b}; end
                    default: begin
                        aa = {9'b0, outa_c}; ab = {9'b0, outb_c};
                        z = {13'b0, zero_c}; w = {13'b0, wrap_c};
                    end
                endcase
                check($sformatf("dut%0d OutA", x.dut), aa, x.outa);
                check($sformatf("dut%0d OutB", x.dut), ab, x.outb);
                check($sformatf("dut%0d Zero", x.dut), z, x.zero);
                check($sformatf("dut%0d Wrap", x.dut), w, x.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(4'b0000, OP_HOLD, 16'h0, 2'd0, 2'd0);
        reset = 1'b0;
        drive(4'b0000, OP_HOLD, 16'h0, 2'd0, 2'd1);

        // Decrement from zero: wrap on A, clamp on B, pulse then clear.
        drive(4'b0001, OP_DEC,  16'h0,    2'd0, 2'd1);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd0, 2'd1);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd0, 2'd1);

        // Shift left drops a 1 from the MSB, then shift right.
        drive(4'b0100, OP_LOAD, 16'h8001, 2'd2, 2'd0);
        drive(4'b0100, OP_SHL,  16'h0,    2'd2, 2'd0);
        drive(4'b0100, OP_SHR,  16'h0,    2'd2, 2'd0);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd2, 2'd0);

        // Low-half load keeps the upper byte.
        drive(4'b0010, OP_LOAD, 16'hAB00, 2'd2, 2'd1);
        drive(4'b0010, OP_LDLO, 16'h12CD, 2'd2, 2'd1);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd3, 2'd1);

        // Write the register being read: old value this cycle, new value next.
        drive(4'b1000, OP_LOAD, 16'h1234, 2'd3, 2'd1);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd3, 2'd1);

        // Increment at all-ones: wrap on A, clamp on B.
        drive(4'b0001, OP_INC,  16'h0,    2'd0, 2'd3);
        drive(4'b0001, OP_LOAD, 16'hFFFF, 2'd0, 2'd3);
        drive(4'b0001, OP_INC,  16'h0,    2'd0, 2'd3);
        drive(4'b1111, OP_DEC,  16'h0,    2'd0, 2'd2);
        drive(4'b0000, OP_HOLD, 16'h0,    2'd1, 2'd2);

        // Reset beats an all-register load in the same cycle.
        reset = 1'b1;
        drive(4'b1111, OP_LOAD, 16'h5A5A, 2'd1, 2'd2);
        reset = 1'b0;
        drive(4'b0000, OP_HOLD, 16'h0,    2'd1, 2'd2);

        // Random traffic with occasional mid-sequence resets.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] iv;
            case ($urandom_range(0, 3))
                0:       iv = 16'h0000;
                1:       iv = 16'hFFFF;
                default: iv = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 40) == 0);
            drive(4'($urandom), funsel_e'(3'($urandom)), iv, 2'($urandom), 2'($urandom));
        end
        reset = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 16'(sb.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_bank
